// File: rtl/renode_ahb_pkg.sv
// Shared AHB types for the Renode cosim bus fabric, plus the arbiter's
// round-robin helper.
package renode_ahb_pkg;

    localparam int MaxManagers = 16;

    typedef enum logic [1:0] {
        Idle   = 2'b00,
        Busy   = 2'b01,
        NonSeq = 2'b10,
        Seq    = 2'b11
    } htrans_e;

    typedef enum logic {
        Okay  = 1'b0,
        Error = 1'b1
    } hresp_e;

    typedef logic [3:0] manager_index_t;

    typedef enum logic {
        IdlePark,
        Owned
    } arb_state_e;

    // Searches pointer+1, pointer+2, ... wrapping at num. pointer itself is
    // visited last. Returns pointer when nothing is requesting.
    function automatic manager_index_t next_rr(
        input logic [MaxManagers-1:0] requests,
        input manager_index_t         pointer,
        input int                     num
    );
        manager_index_t pick;
        logic           found;
        logic [4:0]     idx;
        pick  = pointer;
        found = 1'b0;
        for (int i = 1; i <= MaxManagers; i++) begin
            idx = {1'b0, pointer} + 5'(i);
            if (idx >= 5'(num)) begin
                idx = idx - 5'(num);
            end
            if (i <= num && !found && requests[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/renode_ahb_rr_picker.sv
// Combinational round-robin select: the first requester after the pointer,
// reported both as an index and as a one-hot vector.
module renode_ahb_rr_picker
    import renode_ahb_pkg::*;
#(
    parameter int  NumManagers = 4,
    localparam int IdxW        = $clog2(NumManagers)
) (
    input  logic [NumManagers-1:0] requests,
    input  logic [IdxW-1:0]        pointer,
    output logic [NumManagers-1:0] grant_onehot,
    output logic [IdxW-1:0]        grant_index,
    output logic                   any_request
);

    logic [MaxManagers-1:0] req_ext;
    manager_index_t         pick;

    assign req_ext     = MaxManagers'(requests);
    assign pick        = next_rr(req_ext, 4'(pointer), NumManagers);
    assign grant_index = IdxW'(pick);
    assign any_request = |requests;

    for (genvar gi = 0; gi < NumManagers; gi++) begin : g_onehot
        assign grant_onehot[gi] = any_request && (grant_index == IdxW'(gi));
    end

endmodule

// File: rtl/renode_ahb_arbiter.sv
// Round-robin arbiter sharing one AHB subordinate between several managers;
// grants move only at transfer boundaries and never during a locked sequence.
module renode_ahb_arbiter
    import renode_ahb_pkg::*;
#(
    parameter int  NumManagers    = 4,
    parameter int  AddressWidth   = 32,
    parameter int  DataWidth      = 32,
    parameter int  DefaultManager = 0,
    localparam int IdxW           = $clog2(NumManagers)
) (
    input  logic                              hclk,
    input  logic                              hreset,
    input  logic [NumManagers-1:0]            m_hbusreq,
    input  logic [NumManagers-1:0]            m_hlock,
    input  logic [NumManagers*AddressWidth-1:0] m_haddr,
    input  logic [NumManagers*2-1:0]          m_htrans,
    input  logic [NumManagers-1:0]            m_hwrite,
    input  logic [NumManagers*3-1:0]          m_hsize,
    input  logic [NumManagers*DataWidth-1:0]  m_hwdata,
    output logic [NumManagers-1:0]            m_hgrant,
    output logic                              m_hready,
    output logic [DataWidth-1:0]              m_hrdata,
    output logic                              m_hresp,
    output logic [AddressWidth-1:0]           s_haddr,
    output logic [1:0]                        s_htrans,
    output logic                              s_hwrite,
    output logic [2:0]                        s_hsize,
    output logic [DataWidth-1:0]              s_hwdata,
    output logic                              s_hready,
    input  logic                              s_hreadyout,
    input  logic [DataWidth-1:0]              s_hrdata,
    input  logic                              s_hresp,
    output logic [IdxW-1:0]                   hmaster,
    output logic [IdxW-1:0]                   hmaster_data,
    output logic                              hmastlock
);

    localparam logic [IdxW-1:0]        DefaultIdx    = IdxW'(DefaultManager);
    localparam logic [NumManagers-1:0] DefaultOneHot = NumManagers'(1) << DefaultManager;

    logic [AddressWidth-1:0] addr_arr  [NumManagers];
    logic [1:0]              trans_arr [NumManagers];
    logic [2:0]              size_arr  [NumManagers];
    logic [DataWidth-1:0]    wdata_arr [NumManagers];

    for (genvar gi = 0; gi < NumManagers; gi++) begin : g_unpack
        assign addr_arr[gi]  = m_haddr[gi*AddressWidth +: AddressWidth];
        assign trans_arr[gi] = m_htrans[gi*2 +: 2];
        assign size_arr[gi]  = m_hsize[gi*3 +: 3];
        assign wdata_arr[gi] = m_hwdata[gi*DataWidth +: DataWidth];
    end

    logic [NumManagers-1:0] grant_reg;
    logic [IdxW-1:0]        hmaster_reg;
    logic [IdxW-1:0]        hmaster_data_reg;
    logic                   hmastlock_reg;
    logic                   data_phase_valid_reg;
    logic                   err_term_reg;
    arb_state_e             state_reg;

    htrans_e owner_trans;
    logic    owner_req;
    logic    owner_lock;
    logic    mid_burst;
    logic    park;
    logic    lock_now;
    logic    boundary_raw;
    logic    boundary;

    logic [NumManagers-1:0] pick_onehot;
    logic [IdxW-1:0]        pick_index;
    logic                   pick_any;

    assign owner_trans = htrans_e'(trans_arr[hmaster_reg]);
    assign owner_req   = m_hbusreq[hmaster_reg];
    assign owner_lock  = m_hlock[hmaster_reg];

    // The owner is still mid-burst when its own previous transfer is in data phase.
    assign mid_burst = (state_reg == Owned) && data_phase_valid_reg
                       && (hmaster_data_reg == hmaster_reg);
    assign park      = !owner_req && !mid_burst;

    // The NonSeq that opens a locked sequence already holds the bus.
    assign lock_now     = owner_lock && (hmastlock_reg || owner_trans == NonSeq);
    assign boundary_raw = s_hreadyout && (owner_trans == Idle || owner_trans == NonSeq
                                          || !owner_req || err_term_reg);
    assign boundary     = boundary_raw && !lock_now;

    renode_ahb_rr_picker #(
        .NumManagers (NumManagers)
    ) u_picker (
        .requests     (m_hbusreq),
        .pointer      (hmaster_reg),
        .grant_onehot (pick_onehot),
        .grant_index  (pick_index),
        .any_request  (pick_any)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            grant_reg            <= DefaultOneHot;
            hmaster_reg          <= DefaultIdx;
            hmaster_data_reg     <= DefaultIdx;
            hmastlock_reg        <= 1'b0;
            data_phase_valid_reg <= 1'b0;
            err_term_reg         <= 1'b0;
            state_reg            <= IdlePark;
        end else begin
            if (s_hreadyout) begin
                hmaster_data_reg     <= hmaster_reg;
                data_phase_valid_reg <= (s_htrans == NonSeq) || (s_htrans == Seq);
                err_term_reg         <= 1'b0;
            end else if (hresp_e'(s_hresp) == Error) begin
                err_term_reg <= 1'b1;
            end

            if (s_hreadyout && owner_trans == NonSeq && owner_lock && !park) begin
                hmastlock_reg <= 1'b1;
            end else if (boundary_raw && !owner_lock) begin
                hmastlock_reg <= 1'b0;
            end

            if (boundary) begin
                if (pick_any) begin
                    grant_reg   <= pick_onehot;
                    hmaster_reg <= pick_index;
                    state_reg   <= Owned;
                end else begin
                    grant_reg   <= DefaultOneHot;
                    hmaster_reg <= DefaultIdx;
                    state_reg   <= IdlePark;
                end
            end
        end
    end

    assign s_haddr  = addr_arr[hmaster_reg];
    assign s_htrans = park ? Idle : owner_trans;
    assign s_hwrite = m_hwrite[hmaster_reg];
    assign s_hsize  = size_arr[hmaster_reg];
    assign s_hwdata = wdata_arr[hmaster_data_reg];
    assign s_hready = s_hreadyout;

    assign m_hgrant     = grant_reg;
    assign m_hready     = s_hreadyout;
    assign m_hrdata     = s_hrdata;
    assign m_hresp      = s_hresp;
    assign hmaster      = hmaster_reg;
    assign hmaster_data = hmaster_data_reg;
    assign hmastlock    = hmastlock_reg;

endmodule
